fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, sets the PC and address width in bits.
REQ-002 Parameter IW, default 32, sets the instruction width in bits.
REQ-003 Parameter DEPTH, default 4, sets queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, sets the first fetch address after reset.
REQ-005 One clock; reset is asynchronous and active-high. Ports are clk and rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 redirect  in  1  branch/jump taken; flush and refetch.
REQ-009 redirect_pc  in  XLEN  new fetch address.
REQ-010 imem_req  out  1  fetch request valid.
REQ-011 imem_addr  out  XLEN  fetch address, word aligned.
REQ-012 imem_gnt  in  1  request accepted this cycle.
REQ-013 imem_rvalid  in  1  in-order response valid.
REQ-014 imem_rdata  in  IW  response instruction.
REQ-015 d_valid  out  1  instruction available to decode.
REQ-016 d_ready  in  1  decode accepts the instruction.
REQ-017 d_inst  out  IW  head instruction.
REQ-018 d_pc  out  XLEN  head instruction address + 4.

Function
REQ-019 A request is issued when imem_req && imem_gnt. A request SHALL then advance fetch_pc by 4, modulo 2^XLEN.
REQ-020 imem_req SHALL be 1 only when occupancy + outstanding < DEPTH, rst=0 and redirect=0. This rule means the queue never overflows.
REQ-021 imem_addr SHALL equal fetch_pc, with imem_addr[1:0]=0.
REQ-022 The outstanding count SHALL increment on each request and decrement on each imem_rvalid. Both events in one cycle SHALL leave it unchanged.
REQ-023 When discard=0, an accepted response SHALL push {imem_rdata, resp_pc+4} into the queue. resp_pc SHALL then advance by 4.
REQ-024 A pop SHALL occur when d_valid && d_ready. A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 d_valid SHALL equal (occupancy != 0) && !redirect. In a redirect cycle no handshake occurs.
REQ-026 d_inst and d_pc SHALL hold stable while d_valid=1 and d_ready=0.
REQ-027 Redirect at cycle t SHALL take effect at the next edge:
- occupancy=0, pointers reset;
- fetch_pc=redirect_pc and resp_pc=redirect_pc;
- discard = outstanding after cycle t's updates.
REQ-028 While discard>0, each imem_rvalid SHALL decrement discard and outstanding and SHALL NOT push.
REQ-029 A redirect while discard>0 SHALL reload discard with the current outstanding total.
REQ-030 imem_rvalid with outstanding=0 is a protocol error. It SHALL be ignored and SHALL NOT corrupt state.
REQ-031 Queue pointers SHALL wrap modulo DEPTH. Full is occupancy==DEPTH; empty is occupancy==0.

Reset
REQ-032 rst=1 SHALL immediately force all of the following, independent of clk:
- fetch_pc=RESET_PC, resp_pc=RESET_PC;
- occupancy=0, outstanding=0, discard=0;
- imem_req=0, d_valid=0;
- d_inst=0, d_pc=0.
REQ-033 Reset asserted mid-operation SHALL drop all queued and in-flight instructions. Responses arriving after release SHALL count as the protocol error in REQ-030.
REQ-034 The first request SHALL be issued in the first cycle after rst deasserts, to RESET_PC.

Configuration
REQ-035 Macro FETCH_QUEUE_BYPASS_EN, when defined, SHALL enable bypass. In bypass, when occupancy=0, discard=0 and d_ready=1, a response in cycle t SHALL drive d_valid, d_inst and d_pc combinationally in cycle t. It SHALL NOT enter the queue.
REQ-036 Without FETCH_QUEUE_BYPASS_EN, every response SHALL enter the queue. Minimum response-to-d_valid latency is then one cycle.

Verification
REQ-037 Reset release, imem_gnt=1, 1-cycle memory, d_ready=1 -> addresses 0,4,8,... issued; d_pc 4,8,12,... in order; no gaps after fill.
REQ-038 d_ready=0 for 10 cycles -> exactly DEPTH requests issued (4 at default), then imem_req=0. Entries are held stable and drain in order when d_ready=1.
REQ-039 Redirect to 0x100 with 2 outstanding, responses 0xAAAA0000 and 0xBBBB0000 arriving later -> both dropped; next d_inst is from 0x100 with d_pc=0x104.
REQ-040 Back-to-back redirects to 0x200 then 0x300 with a response in flight -> only instructions from 0x300 onward appear; discard never underflows.
REQ-041 rst asserted mid-stream with queue full -> d_valid=0 and imem_req=0 immediately; after release fetch restarts at RESET_PC.
REQ-042 With FETCH_QUEUE_BYPASS_EN, empty queue, response 0x012A5020 -> d_valid=1 the same cycle. Without the macro -> d_valid=1 the following cycle.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch bus bundle: redirect input, instruction-memory request/response, and decode handshake.
// The fetch queue connects through the master modport; the memory/decode environment uses slave.
interface fetch_queue_if #(
    parameter int XLEN = 32,
    parameter int IW   = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [IW-1:0]   imem_rdata;
    logic            d_valid;
    logic            d_ready;
    logic [IW-1:0]   d_inst;
    logic [XLEN-1:0] d_pc;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, d_ready,
        output imem_req, imem_addr, d_valid, d_inst, d_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, d_ready,
        input  imem_req, imem_addr, d_valid, d_inst, d_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word fetches, buffers in-order responses for decode, flushes on redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [CW-1:0]   occ;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   outst_next;
    logic [CW-1:0]   discard;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] resp_pc4;
    logic [IW-1:0]   inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic req, req_fire, rsp_ok, rsp_drop, rsp_take, bypass, push, pop, head_valid;

    // Request side: in-flight plus buffered never exceeds DEPTH, so pushes always find room
    assign head_valid = (occ != '0);
    assign req        = !rst && !bus.redirect && (({1'b0, occ} + {1'b0, outst}) < DEPTH_C);
    assign req_fire   = req && bus.imem_gnt;

    // Response side: a response with nothing outstanding is stray and leaves state untouched
    assign rsp_ok     = bus.imem_rvalid && (outst != '0);
    assign rsp_drop   = rsp_ok && (discard != '0);
    assign rsp_take   = rsp_ok && (discard == '0);
    assign resp_pc4   = resp_pc + XLEN'(4);
    assign outst_next = outst + CW'(req_fire) - CW'(rsp_ok);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_take && !head_valid && bus.d_ready && !bus.redirect;
`else
    assign bypass = 1'b0;
`endif

    assign push = rsp_take && !bypass;
    assign pop  = head_valid && bus.d_ready && !bus.redirect;

    assign bus.imem_req  = req;
    assign bus.imem_addr = {fetch_pc[XLEN-1:2], 2'b00};
    assign bus.d_valid   = (head_valid || bypass) && !bus.redirect;
    assign bus.d_inst    = head_valid ? inst_mem[rd_ptr] : (bypass ? bus.imem_rdata : '0);
    assign bus.d_pc      = head_valid ? pc_mem[rd_ptr]   : (bypass ? resp_pc4     : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            outst    <= '0;
            discard  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else begin
            outst <= outst_next;
            if (bus.redirect) begin
                // Everything still in flight at this edge belongs to the abandoned path
                occ      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fetch_pc <= bus.redirect_pc;
                resp_pc  <= bus.redirect_pc;
                discard  <= outst_next;
            end else begin
                occ <= occ + CW'(push) - CW'(pop);
                if (push)     wr_ptr   <= wr_ptr + AW'(1);
                if (pop)      rd_ptr   <= rd_ptr + AW'(1);
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_take) resp_pc  <= resp_pc4;
                if (rsp_drop) discard  <= discard - CW'(1);
            end
        end
    end

    // Queue storage is data only; validity is tracked by occ
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]   <= resp_pc4;
        end
    end
endmodule
